// File: rtl/sum_operand_fifo.sv
// Operand-pair FIFO in front of the W-bit prefix adder: buffers {x,y} pairs
// with valid/ready on both sides and a sticky overflow flag for pushes while full.
module sum_operand_fifo #(
   parameter int W     = 6,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     in_valid,
   input  logic [W-1:0]             in_x,
   input  logic [W-1:0]             in_y,
   output logic                     in_ready,
   output logic                     out_valid,
   output logic [W-1:0]             x,
   output logic [W-1:0]             y,
   input  logic                     out_ready,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     ovf
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef struct packed {
      logic [W-1:0] x;
      logic [W-1:0] y;
   } pair_t;

   pair_t          mem [DEPTH];
   logic [AW-1:0]  wr_ptr, rd_ptr;
   logic [CW-1:0]  cnt;
   logic           ovf_q;
   logic           full, push, pop;
   pair_t          head;

   // Handshake flags depend only on registered occupancy, never on the other side.
   assign full      = (cnt == CW'(DEPTH));
   assign in_ready  = !full;
   assign out_valid = (cnt != '0);
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;

   assign head  = mem[rd_ptr];
   // Storage is not reset, so gate the head with out_valid to present zeros when empty.
   assign x     = out_valid ? head.x : '0;
   assign y     = out_valid ? head.y : '0;
   assign count = cnt;
   assign ovf   = ovf_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
         ovf_q  <= 1'b0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
         ovf_q  <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
         if (in_valid && full) ovf_q <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push && !flush && !rst) mem[wr_ptr] <= '{x: in_x, y: in_y};
   end
endmodule

// File: tb/tb_sum_operand_fifo.sv
// Scoreboard bench for sum_operand_fifo: stimulus queues accepted pairs,
// a negedge monitor compares the presented head and retires pairs on pops.
module tb_sum_operand_fifo;
   localparam int W     = 6;
   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic          clk, rst, flush, in_valid, in_ready, out_valid, out_ready, ovf;
   logic [W-1:0]  in_x, in_y, x, y;
   logic [CW-1:0] count;

   int total = 0;
   int bad   = 0;
   logic [2*W-1:0] q [$];
   int   mcnt = 0;
   logic movf = 1'b0;

   sum_operand_fifo #(.W(W), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_x(in_x), .in_y(in_y), .in_ready(in_ready),
      .out_valid(out_valid), .x(x), .y(y), .out_ready(out_ready),
      .count(count), .ovf(ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock of stimulus; expected state after the edge comes from the bench model.
   task automatic step(input logic v, input logic [W-1:0] xi, input logic [W-1:0] yi,
                       input logic rdy, input logic fl);
      logic acc, pp;
      in_valid = v; in_x = xi; in_y = yi; out_ready = rdy; flush = fl;
      acc = v && (mcnt < DEPTH);
      pp  = rdy && (mcnt != 0);
      if (v && mcnt == DEPTH) movf = 1'b1;
      @(posedge clk); #1;
      if (fl) begin
         q.delete(); mcnt = 0; movf = 1'b0;
      end else begin
         if (acc) q.push_back({xi, yi});
         mcnt = mcnt + int'(acc) - int'(pp);
      end
      chk("count",     32'(count),     32'(mcnt));
      chk("in_ready",  32'(in_ready),  32'(mcnt < DEPTH));
      chk("out_valid", 32'(out_valid), 32'(mcnt != 0));
      chk("ovf",       32'(ovf),       32'(movf));
   endtask

   // Monitor: whenever a pair is presented, it must match the scoreboard head.
   always @(negedge clk) begin
      if (!rst && out_valid) begin
         if (q.size() == 0) begin
            chk("unexpected_out_valid", 32'(out_valid), 32'd0);
         end else begin
            chk("head_x", 32'(x), 32'(q[0][2*W-1:W]));
            chk("head_y", 32'(y), 32'(q[0][W-1:0]));
            if (out_ready) void'(q.pop_front());
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [6:0] s;
      rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_x = '0; in_y = '0;
      #1 rst = 1'b1;
      @(posedge clk); @(posedge clk); #1;
      chk("rst_x", 32'(x), 32'd0);
      chk("rst_y", 32'(y), 32'd0);
      rst = 1'b0;
      chk("reset_count",     32'(count),     32'd0);
      chk("reset_in_ready",  32'(in_ready),  32'd1);
      chk("reset_out_valid", 32'(out_valid), 32'd0);
      chk("reset_ovf",       32'(ovf),       32'd0);

      // single pair, one-cycle latency, adder sum check
      step(1'b1, 6'b010101, 6'b001001, 1'b0, 1'b0);
      s = {1'b0, x} + {1'b0, y};
      chk("adder_sum", 32'(s), 32'(7'b0011110));
      chk("first_x", 32'(x), 32'(6'b010101));
      step(1'b0, '0, '0, 1'b1, 1'b0);

      // fill to DEPTH, then an overflow attempt
      step(1'b1, 6'b111000, 6'b010101, 1'b0, 1'b0);
      step(1'b1, 6'b001001, 6'b010110, 1'b0, 1'b0);
      step(1'b1, 6'b011011, 6'b101001, 1'b0, 1'b0);
      step(1'b1, 6'b100110, 6'b000111, 1'b0, 1'b0);
      chk("full_in_ready", 32'(in_ready), 32'd0);
      step(1'b1, 6'b111111, 6'b111111, 1'b0, 1'b0);
      chk("ovf_head_x", 32'(x), 32'(6'b111000));
      chk("ovf_count",  32'(count), 32'd4);
      step(1'b0, '0, '0, 1'b0, 1'b0);

      // drain in FIFO order
      for (int i = 0; i < DEPTH; i++) step(1'b0, '0, '0, 1'b1, 1'b0);
      chk("drained_count", 32'(count), 32'd0);

      // steady push+pop from count=1, pointers wrap twice
      step(1'b1, 6'b000001, 6'b100000, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++)
         step(1'b1, W'(6'd10 + i), W'(6'd40 - i), 1'b1, 1'b0);
      chk("stream_count", 32'(count), 32'd1);
      step(1'b0, '0, '0, 1'b1, 1'b0);

      // flush at count=3 with push and pop requested
      step(1'b1, 6'b000011, 6'b000100, 1'b0, 1'b0);
      step(1'b1, 6'b000101, 6'b000110, 1'b0, 1'b0);
      step(1'b1, 6'b000111, 6'b001000, 1'b0, 1'b0);
      step(1'b1, 6'b101010, 6'b010101, 1'b1, 1'b1);
      chk("flush_count", 32'(count), 32'd0);
      chk("flush_ovf",   32'(ovf),   32'd0);
      flush = 1'b0;

      // asynchronous reset mid-stream
      step(1'b1, 6'b110011, 6'b001100, 1'b0, 1'b0);
      step(1'b1, 6'b011110, 6'b100001, 1'b0, 1'b0);
      in_valid = 1'b0; out_ready = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("async_rst_count",     32'(count),     32'd0);
      chk("async_rst_out_valid", 32'(out_valid), 32'd0);
      chk("async_rst_in_ready",  32'(in_ready),  32'd1);
      chk("async_rst_x",         32'(x),         32'd0);
      chk("async_rst_y",         32'(y),         32'd0);
      q.delete(); mcnt = 0; movf = 1'b0;
      @(posedge clk); #1 rst = 1'b0;
      step(1'b1, 6'b101101, 6'b010010, 1'b0, 1'b0);
      chk("post_rst_head_x", 32'(x), 32'(6'b101101));
      step(1'b0, '0, '0, 1'b1, 1'b0);
      step(1'b0, '0, '0, 1'b0, 1'b0);
      chk("scoreboard_empty", 32'(q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/sum_operand_fifo.md
SUM_OPERAND_FIFO -- requirements
Module: sum_operand_fifo

Interface
REQ-001 SHALL have parameter W, default 6, the operand width; it matches the x/y width of the downstream 6-bit prefix adder.
REQ-002 SHALL have parameter DEPTH, default 4, the number of stored operand pairs; it is a power of two, at least 2.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port flush, input, 1 bit: synchronous clear of all stored pairs.
REQ-006 SHALL have port in_valid, input, 1 bit: the upstream producer offers a pair.
REQ-007 SHALL have port in_x, input, W bits: operand x offered upstream.
REQ-008 SHALL have port in_y, input, W bits: operand y offered upstream.
REQ-009 SHALL have port in_ready, output, 1 bit: the FIFO can accept a pair this cycle.
REQ-010 SHALL have port out_valid, output, 1 bit: x,y hold a valid pair for the adder.
REQ-011 SHALL have port x, output, W bits: operand x driven to the adder.
REQ-012 SHALL have port y, output, W bits: operand y driven to the adder.
REQ-013 SHALL have port out_ready, input, 1 bit: the downstream consumer accepts the current pair.
REQ-014 SHALL have port count, output, clog2(DEPTH)+1 bits: number of stored pairs.
REQ-015 SHALL have port ovf, output, 1 bit: sticky flag set by a push attempt while full.

Function
REQ-016 SHALL define a push as in_valid and in_ready both high at a rising clk edge; the pair {in_x,in_y} is written at the tail.
REQ-017 SHALL define a pop as out_valid and out_ready both high at a rising clk edge; the head pair is removed.
REQ-018 SHALL drive in_ready = (count < DEPTH) combinationally from registered state only, with no dependence on out_ready.
REQ-019 SHALL drive out_valid = (count != 0), with x,y equal to the head entry, from registered state, with no combinational path from in_* to x/y.
REQ-020 SHALL have a latency of one cycle: a pair pushed at edge N is visible on x,y with out_valid=1 after edge N when the FIFO was empty before it.
REQ-021 SHALL keep x,y and out_valid stable while out_valid=1 and out_ready=0.
REQ-022 SHALL, on a simultaneous push and pop, leave count unchanged and advance both pointers; when count=DEPTH a push is impossible because in_ready=0.
REQ-023 SHALL, on simultaneous push and pop with count=1, present the new pair on x,y after the edge.
REQ-024 SHALL wrap the read and write pointers modulo DEPTH without a gap or bubble.
REQ-025 SHALL set ovf at the edge where in_valid=1 and count=DEPTH; ovf stays set until rst or flush; no data changes.
REQ-026 SHALL, on flush=1, at the edge set count=0, both pointers to 0 and ovf to 0, taking priority over a push and a pop in the same cycle.
REQ-027 SHALL keep stored data unchanged when neither a push nor a pop occurs.
REQ-028 SHALL produce x and y with the adder's bit order: bit W-1 is the MSB.

Reset
REQ-029 SHALL, on rst=1, immediately and without a clock, force count=0, pointers=0, ovf=0, out_valid=0 and in_ready=1.
REQ-030 SHALL force x=0 and y=0 during reset; storage contents need not be cleared.
REQ-031 SHALL discard in-flight pairs when rst is asserted mid-operation; the first push after deassertion becomes the head.

Verification
REQ-032 SHALL be covered by a bench scenario: after reset, push (010101,001001) -> next cycle out_valid=1, x=010101, y=001001, count=1; the downstream adder gives s=0011110.
REQ-033 SHALL be covered by a bench scenario: push 4 pairs with out_ready=0 -> count=4, in_ready=0; a 5th in_valid -> ovf=1, count stays 4 and the head is unchanged.
REQ-034 SHALL be covered by a bench scenario: fill, then drain with out_ready=1 -> pairs emerge in FIFO order (111000/010101, 001001/010110, 011011/101001, ...) and count reaches 0.
REQ-035 SHALL be covered by a bench scenario: continuous push and pop for 10 cycles from count=1 -> count stays 1 and the pointers wrap twice with no loss.
REQ-036 SHALL be covered by a bench scenario: flush with in_valid=1 and out_ready=1 at count=3 -> count=0, ovf=0, out_valid=0 after the edge.
REQ-037 SHALL be covered by a bench scenario: assert rst asynchronously mid-stream -> outputs are at reset values before the next clk edge, and the next push appears as the head.
